// File: rtl/ex_stage.sv
// Execute stage: combinational ALU feeding the EX/MEM pipeline register, plus the
// WWD output port, the sticky HLT latch and the retired-instruction counter.
module ex_stage #(
  parameter int WORD   = 16,
  parameter int REGIDX = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid_in,
  input  logic [3:0]        alu_ctrl,
  input  logic [WORD-1:0]   op_a,
  input  logic [WORD-1:0]   op_b,
  input  logic [WORD-1:0]   store_data_in,
  input  logic [REGIDX-1:0] dest_in,
  input  logic              reg_write_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              stall_in,
  input  logic              flush_in,
  output logic              ready_out,
  output logic              valid_out,
  output logic [WORD-1:0]   alu_result,
  output logic [WORD-1:0]   store_data_out,
  output logic [REGIDX-1:0] dest_out,
  output logic              reg_write_out,
  output logic              mem_read_out,
  output logic              mem_write_out,
  output logic [WORD-1:0]   output_port,
  output logic              halted,
  output logic [15:0]       num_inst
);

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_ORR = 4'b0011,
    ALU_NOT = 4'b0100,
    ALU_TCP = 4'b0101,
    ALU_SHL = 4'b0110,
    ALU_SHR = 4'b0111,
    ALU_LHI = 4'b1000,
    ALU_WWD = 4'b1101,
    ALU_HLT = 4'b1111
  } alu_op_e;

  logic [WORD-1:0]   alu_d;
  logic              acc;
  logic              is_wwd;
  logic              is_hlt;

  logic              valid_q;
  logic [WORD-1:0]   result_q;
  logic [WORD-1:0]   store_data_q;
  logic [REGIDX-1:0] dest_q;
  logic              reg_write_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [WORD-1:0]   output_port_q;
  logic              halted_q;
  logic [15:0]       num_inst_q;

  // NOTE: the default assignment before the case keeps this block free of latches
  // for codes the case does not list.
  always_comb begin
    alu_d = '0;
    case (alu_op_e'(alu_ctrl))
      ALU_ADD: alu_d = op_a + op_b;
      ALU_SUB: alu_d = op_a - op_b;
      ALU_AND: alu_d = op_a & op_b;
      ALU_ORR: alu_d = op_a | op_b;
      ALU_NOT: alu_d = ~op_a;
      ALU_TCP: alu_d = ~op_a + 1'b1;
      ALU_SHL: alu_d = {op_a[WORD-2:0], 1'b0};
      ALU_SHR: alu_d = {op_a[WORD-1], op_a[WORD-1:1]};
      ALU_LHI: alu_d = {op_b[7:0], {(WORD-8){1'b0}}};
      ALU_WWD: alu_d = op_a;
      default: alu_d = '0;
    endcase
  end

  assign acc    = valid_in & ~stall_in & ~flush_in & ~halted_q;
  assign is_wwd = (alu_ctrl == ALU_WWD);
  assign is_hlt = (alu_ctrl == ALU_HLT);

  // NOTE: state registers use non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q       <= 1'b0;
      result_q      <= '0;
      store_data_q  <= '0;
      dest_q        <= '0;
      reg_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      output_port_q <= '0;
      halted_q      <= 1'b0;
      num_inst_q    <= '0;
    end else if (!stall_in) begin
      if (acc) begin
        valid_q      <= 1'b1;
        result_q     <= alu_d;
        store_data_q <= store_data_in;
        dest_q       <= dest_in;
        // HLT retires as a valid slot but must never touch registers or memory.
        reg_write_q  <= reg_write_in & ~is_hlt;
        mem_read_q   <= mem_read_in  & ~is_hlt;
        mem_write_q  <= mem_write_in & ~is_hlt;
        num_inst_q   <= num_inst_q + 16'd1;
        if (is_wwd) output_port_q <= op_a;
        if (is_hlt) halted_q      <= 1'b1;
      end else begin
        valid_q      <= 1'b0;
        result_q     <= '0;
        store_data_q <= '0;
        dest_q       <= '0;
        reg_write_q  <= 1'b0;
        mem_read_q   <= 1'b0;
        mem_write_q  <= 1'b0;
      end
    end
  end

  assign ready_out      = ~stall_in;
  assign valid_out      = valid_q;
  assign alu_result     = result_q;
  assign store_data_out = store_data_q;
  assign dest_out       = dest_q;
  assign reg_write_out  = reg_write_q;
  assign mem_read_out   = mem_read_q;
  assign mem_write_out  = mem_write_q;
  assign output_port    = output_port_q;
  assign halted         = halted_q;
  assign num_inst       = num_inst_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed vectors push expected EX/MEM contents,
// a monitor pops and compares whenever a freshly loaded valid slot appears.
module tb_ex_stage;

  localparam int WORD   = 16;
  localparam int REGIDX = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              valid_in;
  logic [3:0]        alu_ctrl;
  logic [WORD-1:0]   op_a, op_b, store_data_in;
  logic [REGIDX-1:0] dest_in;
  logic              reg_write_in, mem_read_in, mem_write_in;
  logic              stall_in, flush_in;
  logic              ready_out, valid_out;
  logic [WORD-1:0]   alu_result, store_data_out;
  logic [REGIDX-1:0] dest_out;
  logic              reg_write_out, mem_read_out, mem_write_out;
  logic [WORD-1:0]   output_port;
  logic              halted;
  logic [15:0]       num_inst;

  ex_stage #(.WORD(WORD), .REGIDX(REGIDX)) dut (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .alu_ctrl(alu_ctrl),
    .op_a(op_a), .op_b(op_b), .store_data_in(store_data_in), .dest_in(dest_in),
    .reg_write_in(reg_write_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .stall_in(stall_in), .flush_in(flush_in), .ready_out(ready_out), .valid_out(valid_out),
    .alu_result(alu_result), .store_data_out(store_data_out), .dest_out(dest_out),
    .reg_write_out(reg_write_out), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .output_port(output_port), .halted(halted), .num_inst(num_inst)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WORD-1:0]   res;
    logic [WORD-1:0]   sd;
    logic [REGIDX-1:0] dest;
    logic              rw, mr, mw;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic took  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // A slot is new only if the previous edge was not a stall edge.
  always @(posedge clk) took <= reset_n & ~stall_in;

  always @(negedge clk) begin
    if (reset_n && took && valid_out) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_valid", 32'(valid_out), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_alu_result", 32'(alu_result),     32'(e.res));
        check("sb_store_data", 32'(store_data_out), 32'(e.sd));
        check("sb_dest",       32'(dest_out),       32'(e.dest));
        check("sb_ctrl",       {29'd0, reg_write_out, mem_read_out, mem_write_out},
                               {29'd0, e.rw, e.mr, e.mw});
      end
    end
  end

  task automatic drive(input logic [3:0] ctrl, input logic [WORD-1:0] a, input logic [WORD-1:0] b,
                       input logic [WORD-1:0] sd, input logic [REGIDX-1:0] dst,
                       input logic rw, input logic mr, input logic mw, input logic fl);
    valid_in      = 1'b1;
    alu_ctrl      = ctrl;
    op_a          = a;
    op_b          = b;
    store_data_in = sd;
    dest_in       = dst;
    reg_write_in  = rw;
    mem_read_in   = mr;
    mem_write_in  = mw;
    flush_in      = fl;
  endtask

  // Present one instruction for one non-stalled edge; push its expectation if accepted.
  task automatic send(input logic [3:0] ctrl, input logic [WORD-1:0] a, input logic [WORD-1:0] b,
                      input logic [WORD-1:0] sd, input logic [REGIDX-1:0] dst,
                      input logic rw, input logic mr, input logic mw, input logic fl,
                      input logic exp_acc, input logic [WORD-1:0] exp_res,
                      input logic exp_rw, input logic exp_mr, input logic exp_mw);
    exp_t e;
    drive(ctrl, a, b, sd, dst, rw, mr, mw, fl);
    stall_in = 1'b0;
    if (exp_acc) begin
      e.res = exp_res; e.sd = sd; e.dest = dst; e.rw = exp_rw; e.mr = exp_mr; e.mw = exp_mw;
      sb.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    valid_in = 1'b0; flush_in = 1'b0; stall_in = 1'b0;
    alu_ctrl = 4'd0; op_a = '0; op_b = '0; store_data_in = '0; dest_in = '0;
    reg_write_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid_out",   32'(valid_out),     32'd0);
    check("rst_alu_result",  32'(alu_result),    32'd0);
    check("rst_reg_write",   32'(reg_write_out), 32'd0);
    check("rst_output_port", 32'(output_port),   32'd0);
    check("rst_halted",      32'(halted),        32'd0);
    check("rst_num_inst",    32'(num_inst),      32'd0);
    check("rst_ready_out",   32'(ready_out),     32'd1);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // ADD overflow into the sign bit, then every opcode back to back.
    send(4'b0000, 16'h7FFF, 16'h0001, 16'h0000, 2'd1, 1, 0, 0, 0, 1, 16'h8000, 1, 0, 0);
    check("add_valid_out", 32'(valid_out), 32'd1);
    check("add_num_inst",  32'(num_inst),  32'd1);
    send(4'b0001, 16'h0005, 16'h0003, 16'h0000, 2'd2, 1, 0, 0, 0, 1, 16'h0002, 1, 0, 0);
    send(4'b0010, 16'hF0F0, 16'hFF00, 16'h0000, 2'd3, 1, 0, 0, 0, 1, 16'hF000, 1, 0, 0);
    send(4'b0011, 16'h00F0, 16'h0F00, 16'h0000, 2'd0, 1, 0, 0, 0, 1, 16'h0FF0, 1, 0, 0);
    send(4'b0100, 16'h00FF, 16'h1234, 16'h0000, 2'd1, 1, 0, 0, 0, 1, 16'hFF00, 1, 0, 0);
    send(4'b0101, 16'h0003, 16'h0000, 16'h0000, 2'd2, 1, 0, 0, 0, 1, 16'hFFFD, 1, 0, 0);
    send(4'b0110, 16'h4001, 16'h0000, 16'h0000, 2'd3, 1, 0, 0, 0, 1, 16'h8002, 1, 0, 0);
    send(4'b0111, 16'h8004, 16'h0000, 16'h0000, 2'd0, 1, 0, 0, 0, 1, 16'hC002, 1, 0, 0);
    send(4'b1000, 16'h1234, 16'h00AB, 16'h0000, 2'd1, 1, 0, 0, 0, 1, 16'hAB00, 1, 0, 0);
    send(4'b1010, 16'h0005, 16'h0006, 16'h0000, 2'd2, 1, 0, 0, 0, 1, 16'h0000, 1, 0, 0);
    send(4'b0000, 16'h0002, 16'h0004, 16'hBEEF, 2'd0, 0, 0, 1, 0, 1, 16'h0006, 0, 0, 1);
    send(4'b0000, 16'h0008, 16'h0002, 16'h0000, 2'd3, 1, 1, 0, 0, 1, 16'h000A, 1, 1, 0);
    check("b2b_num_inst", 32'(num_inst), 32'd12);

    // WWD updates the port; a flushed WWD leaves everything alone.
    send(4'b1101, 16'h1234, 16'h0000, 16'h0000, 2'd0, 0, 0, 0, 0, 1, 16'h1234, 0, 0, 0);
    check("wwd_output_port", 32'(output_port),   32'h1234);
    check("wwd_reg_write",   32'(reg_write_out), 32'd0);
    send(4'b1101, 16'h5678, 16'h0000, 16'h0000, 2'd0, 0, 0, 0, 1, 0, 16'h0000, 0, 0, 0);
    check("flush_output_port", 32'(output_port), 32'h1234);
    check("flush_valid_out",   32'(valid_out),   32'd0);
    check("flush_num_inst",    32'(num_inst),    32'd13);

    // Stall holds a valid EX/MEM slot for three edges.
    send(4'b0000, 16'h0001, 16'h0001, 16'h0000, 2'd1, 1, 0, 0, 0, 1, 16'h0002, 1, 0, 0);
    drive(4'b0001, 16'h0005, 16'h0007, 16'h0000, 2'd2, 1, 0, 0, 0);
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("stall_ready_out", 32'(ready_out),  32'd0);
      check("stall_valid_out", 32'(valid_out),  32'd1);
      check("stall_alu",       32'(alu_result), 32'h0002);
      check("stall_num_inst",  32'(num_inst),   32'd14);
    end
    send(4'b0001, 16'h0005, 16'h0007, 16'h0000, 2'd2, 1, 0, 0, 0, 1, 16'hFFFE, 1, 0, 0);
    check("unstall_num_inst", 32'(num_inst), 32'd15);

    // HLT retires with enables cleared, then everything becomes a bubble.
    send(4'b1111, 16'h0009, 16'h0000, 16'h0000, 2'd3, 1, 1, 1, 0, 1, 16'h0000, 0, 0, 0);
    check("hlt_halted",   32'(halted),   32'd1);
    check("hlt_num_inst", 32'(num_inst), 32'd16);
    send(4'b0000, 16'h0001, 16'h0002, 16'h0000, 2'd1, 1, 0, 0, 0, 0, 16'h0000, 0, 0, 0);
    check("halt_valid_out", 32'(valid_out), 32'd0);
    check("halt_num_inst",  32'(num_inst),  32'd16);
    check("halt_sticky",    32'(halted),    32'd1);

    idle();
    #2 reset_n = 1'b0;
    #1;
    check("rerst_halted",      32'(halted),      32'd0);
    check("rerst_output_port", 32'(output_port), 32'd0);
    check("rerst_num_inst",    32'(num_inst),    32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Counter wrap: 65535 accepted NOP-ADDs reach 0xFFFF, one more wraps to zero.
    for (int i = 0; i < 65535; i++)
      send(4'b0000, 16'h0000, 16'h0000, 16'h0000, 2'd0, 0, 0, 0, 0, 1, 16'h0000, 0, 0, 0);
    check("wrap_ffff", 32'(num_inst), 32'h0000FFFF);
    send(4'b0000, 16'h0000, 16'h0000, 16'h0000, 2'd0, 0, 0, 0, 0, 1, 16'h0000, 0, 0, 0);
    check("wrap_zero", 32'(num_inst), 32'd0);

    idle();
    repeat (2) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the pipelined CPU, directly downstream of the ALU control decoder.
- Consumes the 4-bit ALU control code plus ID/EX operands and control bits, and computes the ALU result combinationally.
- Registers the result and control into the EX/MEM pipeline register.
- Owns the architectural side effects of WWD (output port register) and HLT (sticky halt latch), and counts retired EX instructions.

Parameters:
- WORD, 16, datapath width in bits (must be >= 9).
- REGIDX, 2, register index width.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- valid_in  in  1  ID/EX slot holds a real instruction.
- alu_ctrl  in  4  code from the ALU control decoder.
- op_a  in  WORD  first operand (rs value, forwarded).
- op_b  in  WORD  second operand (rt value or extended immediate).
- store_data_in  in  WORD  data for SWD.
- dest_in  in  REGIDX  write-back register index.
- reg_write_in  in  1  write-back enable.
- mem_read_in  in  1  LWD.
- mem_write_in  in  1  SWD.
- stall_in  in  1  downstream (MEM) cannot accept; hold EX/MEM.
- flush_in  in  1  kill the instruction currently in EX.
- ready_out  out  1  EX can accept this cycle (= ~stall_in).
- valid_out  out  1  EX/MEM slot valid.
- alu_result  out  WORD  registered ALU result.
- store_data_out  out  WORD  registered store data.
- dest_out  out  REGIDX  registered destination.
- reg_write_out, mem_read_out, mem_write_out  out  1 each  registered control.
- output_port  out  WORD  last WWD value.
- halted  out  1  sticky halt flag.
- num_inst  out  16  retired-instruction counter.

Behaviour:
- Reset (reset_n low, async): every output register is 0, including valid_out, alu_result, all control bits, output_port, halted and num_inst.
- ALU function, combinational, mod 2^WORD:
  - 0000 ADD: a+b.
  - 0001 SUB: a-b.
  - 0010 AND.
  - 0011 ORR.
  - 0100 NOT: ~a.
  - 0101 TCP: ~a+1.
  - 0110 SHL: a<<1.
  - 0111 SHR: arithmetic shift right by 1, MSB replicated.
  - 1000 LHI: {b[7:0], zeros}.
  - 1101 WWD: a.
  - 1111 HLT: 0.
  - Any other code: 0.
- Accept condition: acc = valid_in & ~stall_in & ~flush_in & ~halted.
- Rising edge with stall_in=1: all EX/MEM registers, output_port, halted and num_inst hold their values. Stall has priority over flush; upstream re-presents the instruction.
- Rising edge with stall_in=0:
  - If acc: EX/MEM loads the ALU result and *_in fields; valid_out=1.
  - Otherwise EX/MEM loads a bubble: valid_out=0, all write/read enables 0, data fields 0.
- Latency: one cycle from an accepted input to valid_out.
- WWD: when acc and alu_ctrl=1101, output_port <= op_a at that edge. Otherwise output_port holds.
- HLT:
  - When acc and alu_ctrl=1111, halted <= 1 at that edge. The HLT itself enters EX/MEM as a valid instruction with all enables 0.
  - Once halted=1, every later input becomes a bubble; only reset clears halted.
- num_inst increments by 1 on every acc edge, including HLT. It wraps from 0xFFFF to 0.
- Back-to-back: one instruction per cycle with no bubbles when stall_in=0.
- Reset asserted mid-stall or mid-halt: everything returns to 0 immediately.

Test Plan:
- Reset, then ADD with a=0x7FFF, b=0x0001 and valid, no stall -> next cycle alu_result=0x8000, valid_out=1, num_inst=1.
- SHR a=0x8004 -> 0xC002; TCP a=0x0003 -> 0xFFFD; LHI b=0x00AB -> 0xAB00; undefined code 1010 -> 0x0000.
- WWD a=0x1234 -> output_port=0x1234 after one edge, reg_write_out=0. A following WWD with flush_in=1 -> output_port stays 0x1234, valid_out=0, num_inst unchanged.
- Present SUB a=5, b=7 with stall_in=1 held for 3 cycles -> EX/MEM outputs and num_inst frozen, ready_out=0. Release -> alu_result=0xFFFE on the next edge.
- HLT accepted, then ADD presented -> halted=1, then ADD yields valid_out=0 and num_inst stops. Pulse reset_n low -> halted=0, output_port=0.
- Preload num_inst to 0xFFFF via 65535 accepted NOP-ADDs, then one more -> num_inst=0x0000.
